mrd_st_framer_fifo: RTL
=======================

MRD_ST_FRAMER_FIFO -- requirements
Module: mrd_st_framer_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter DW, default 18: width of each of the real and imaginary sample fields.
REQ-003 Parameter PTS_W, default 12: width of the DFT-points field.
REQ-004 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of 2, at least 4.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid, in_sop, in_eop  in  1 each  sink beat qualifiers.
REQ-008 in_ready  out  1  sink may accept the beat.
REQ-009 in_real, in_imag  in  DW each  sample.
REQ-010 in_dftpts  in  PTS_W  frame length; sampled on the sop beat only.
REQ-011 in_inverse  in  1  IDFT flag; sampled on the sop beat only.
REQ-012 out_valid, out_sop, out_eop, out_real, out_imag, out_dftpts, out_inverse  out  (1,1,1,DW,DW,PTS_W,1)  source beat.
REQ-013 out_ready  in  1  downstream accepts.
REQ-014 stat_sink_sop  out  1  one-cycle pulse on an accepted sop.
REQ-015 stat_dftpts  out  PTS_W  latched length of the current or last frame.
REQ-016 stat_sink_ongoing  out  1  a frame is being received.
REQ-017 err_sop, err_len  out  1 each  one-cycle error pulses.
REQ-018 level  out  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 Accept = in_valid & in_ready; in_ready SHALL equal (level != DEPTH), with no dependence on out_ready.
REQ-020 FSM states: IDLE and FRAME.
REQ-021 IDLE, accepted beat with in_sop=1: latch dftpts (L = in_dftpts; L=0 means 2^PTS_W) and inverse; beat count = 1; pulse stat_sink_sop; go to FRAME unless L=1.
REQ-022 IDLE, accepted beat with in_sop=0: the beat SHALL be consumed and discarded (not written) and err_sop pulsed.
REQ-023 FRAME, each accepted beat: written to the FIFO and beat count incremented.
REQ-024 A sop beat accepted in FRAME SHALL be written as data with sop=0, and err_sop pulsed.
REQ-025 The beat with count == L SHALL be written with eop=1, and the FSM returns to IDLE.
REQ-026 If in_eop=0 on the count == L beat, err_len SHALL be pulsed.
REQ-027 If in_eop=1 arrives with count < L, the beat SHALL be written with eop=1, err_len pulsed, and the FSM returns to IDLE (truncated frame).
REQ-028 A single-beat frame (L=1) SHALL be written with sop=1 and eop=1 and stay in IDLE.
REQ-029 Every written entry stores {sop, eop, real, imag, latched dftpts, latched inverse}; out_dftpts and out_inverse SHALL be constant across a frame.
REQ-030 stat_sink_ongoing SHALL equal (state == FRAME).
REQ-031 stat_dftpts updates on an accepted sop and holds otherwise.
REQ-032 out_valid SHALL equal (level != 0); the out_* fields are the head entry.
REQ-033 Pop occurs on out_valid & out_ready.
REQ-034 Latency: a beat accepted at edge N SHALL be visible on out_* after edge N (out_valid high in cycle N+1 if the FIFO was empty); no combinational in-to-out path.
REQ-035 Simultaneous push and pop SHALL leave level unchanged.
REQ-036 Pointers SHALL wrap modulo DEPTH.
REQ-037 Discarded beats do not change level.
REQ-038 Counts SHALL be PTS_W+1 bits wide so that L = 2^PTS_W is representable.
REQ-039 out_* fields while out_valid=0 are don't-care.

Reset
REQ-040 While rst_n=0, all state SHALL clear asynchronously: state=IDLE, pointers and level 0.
REQ-041 Reset values: in_ready=1, out_valid=0, out_sop=0, out_eop=0, stat_sink_sop=0, stat_dftpts=0, stat_sink_ongoing=0, err_sop=0, err_len=0.
REQ-042 Reset mid-frame SHALL discard all buffered and partial data, with no error pulse.

Verification
REQ-043 dftpts=12, 12 beats with sop on the first and eop on the last, out_ready=1 -> 12 outputs, one sop and one eop, out_dftpts=12, no errors, output 1 cycle after input.
REQ-044 out_ready=0, 20 beats offered with DEPTH=16 -> in_ready falls after 16 accepts with level=16; out_ready=1 then drains in order with no loss or duplication.
REQ-045 dftpts=8 with in_eop on beat 5 -> output eop on beat 5, err_len pulse, next sop accepted normally; dftpts=4 with no in_eop -> eop forced on beat 4, err_len pulse.
REQ-046 Beat without sop in IDLE -> discarded, err_sop pulse, level unchanged; sop mid-frame -> written with sop=0, err_sop pulse.
REQ-047 dftpts=1 -> single output with sop=1 and eop=1, stat_sink_ongoing stays 0; dftpts=0 -> frame of 4096 beats.
REQ-048 rst_n asserted after 3 beats of an 8-beat frame -> out_valid=0, level=0, state IDLE; a following full frame passes clean.

Source files
------------

// File: rtl/mrd_st_framer_fifo.sv
// mrd_st_framer_fifo: streaming sample framer in front of a show-ahead FIFO.
// The sop beat latches the frame length and the IDFT flag. Every later beat of
// the frame is tagged with the latched values. The last beat of the frame is
// marked eop, and sop/eop/length protocol errors raise one-cycle pulses.
module mrd_st_framer_fifo #(
  parameter int DW    = 18,
  parameter int PTS_W = 12,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sop,
  input  logic                         in_eop,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_real,
  input  logic [DW-1:0]                in_imag,
  input  logic [PTS_W-1:0]             in_dftpts,
  input  logic                         in_inverse,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [DW-1:0]                out_real,
  output logic [DW-1:0]                out_imag,
  output logic [PTS_W-1:0]             out_dftpts,
  output logic                         out_inverse,
  input  logic                         out_ready,
  output logic                         stat_sink_sop,
  output logic [PTS_W-1:0]             stat_dftpts,
  output logic                         stat_sink_ongoing,
  output logic                         err_sop,
  output logic                         err_len,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int EW    = 2 * DW + PTS_W + 3;

  localparam logic [PTS_W:0]   CNT_ONE  = {{PTS_W{1'b0}}, 1'b1};
  localparam logic [PTS_W:0]   CNT_MAX  = {1'b1, {PTS_W{1'b0}}};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic {IDLE, FRAME} state_t;

  state_t           state_q, state_d;
  logic [PTS_W:0]   cnt_q, cnt_d;
  logic [PTS_W:0]   len_q, len_d;
  logic [PTS_W-1:0] dftpts_q, dftpts_d;
  logic             inv_q, inv_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             sop_pls_q, sop_pls_d;
  logic             err_sop_q, err_sop_d;
  logic             err_len_q, err_len_d;

  logic [EW-1:0]    mem_q [DEPTH];

  logic             accept;
  logic             pop;
  logic             push;
  logic [PTS_W:0]   len_in;
  logic [PTS_W:0]   beat_cnt;
  logic [PTS_W:0]   beat_len;
  logic             wr_sop;
  logic             wr_eop;
  logic [PTS_W-1:0] wr_pts;
  logic             wr_inv;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    head;

  // Handshakes and the decoded frame length (0 encodes 2^PTS_W)
  assign in_ready  = (level_q != LVL_FULL);
  assign out_valid = (level_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign len_in    = (in_dftpts == '0) ? CNT_MAX : {1'b0, in_dftpts};

  // Framing FSM: decides whether an accepted beat is stored and how it is tagged
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    dftpts_d  = dftpts_q;
    inv_d     = inv_q;
    push      = 1'b0;
    wr_sop    = 1'b0;
    wr_eop    = 1'b0;
    wr_pts    = dftpts_q;
    wr_inv    = inv_q;
    sop_pls_d = 1'b0;
    err_sop_d = 1'b0;
    err_len_d = 1'b0;
    beat_cnt  = cnt_q + CNT_ONE;
    beat_len  = len_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_sop) begin
            push      = 1'b1;
            wr_sop    = 1'b1;
            dftpts_d  = in_dftpts;
            inv_d     = in_inverse;
            len_d     = len_in;
            wr_pts    = in_dftpts;
            wr_inv    = in_inverse;
            sop_pls_d = 1'b1;
            beat_cnt  = CNT_ONE;
            beat_len  = len_in;
            state_d   = FRAME;
          end else begin
            // Stray beat outside a frame is dropped
            err_sop_d = 1'b1;
          end
        end
        FRAME: begin
          push      = 1'b1;
          err_sop_d = in_sop;
        end
        default: state_d = IDLE;
      endcase
      if (push) begin
        cnt_d = beat_cnt;
        if (beat_cnt == beat_len) begin
          wr_eop    = 1'b1;
          err_len_d = ~in_eop;
          state_d   = IDLE;
        end else if (in_eop) begin
          // Early eop truncates the frame
          wr_eop    = 1'b1;
          err_len_d = 1'b1;
          state_d   = IDLE;
        end
      end
    end
  end

  assign wr_entry = {wr_sop, wr_eop, in_real, in_imag, wr_pts, wr_inv};

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      dftpts_q  <= '0;
      inv_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sop_pls_q <= 1'b0;
      err_sop_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      dftpts_q  <= dftpts_d;
      inv_q     <= inv_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sop_pls_q <= sop_pls_d;
      err_sop_q <= err_sop_d;
      err_len_q <= err_len_d;
    end
  end

  // Entry storage; contents are qualified by level, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head entry presented directly (show-ahead); sop/eop gated so they read 0 when empty
  assign head        = mem_q[rd_ptr_q];
  assign out_sop     = out_valid & head[EW-1];
  assign out_eop     = out_valid & head[EW-2];
  assign out_real    = head[EW-3 -: DW];
  assign out_imag    = head[EW-3-DW -: DW];
  assign out_dftpts  = head[PTS_W:1];
  assign out_inverse = head[0];

  assign stat_sink_sop     = sop_pls_q;
  assign stat_dftpts       = dftpts_q;
  assign stat_sink_ongoing = (state_q == FRAME);
  assign err_sop           = err_sop_q;
  assign err_len           = err_len_q;
  assign level             = level_q;

endmodule
